// File: rtl/fft_out_serializer_if.sv
// ============================================================================
// Module  : fft_out_serializer_if
// Brief   : Valid/ready sample stream carried out of the FFT frame unloader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_out_serializer_if #(
   parameter int N   = 16,
   parameter int MSB = 16
);
   logic [MSB-1:0]         data_out;
   logic                   out_valid;
   logic                   out_ready;
   logic [$clog2(N)-1:0]   out_index;
   logic                   out_last;

   modport master (
      output data_out,
      output out_valid,
      output out_index,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  data_out,
      input  out_valid,
      input  out_index,
      input  out_last,
      output out_ready
   );
endinterface

`default_nettype wire

// File: rtl/fft_out_serializer.sv
// ============================================================================
// Module  : fft_out_serializer
// Brief   : Captures a parallel FFT frame and streams it out sample by sample,
//           with a one-frame shadow buffer and natural/bit-reversed ordering.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_out_serializer #(
   parameter int N       = 16,
   parameter int MSB     = 16,
   parameter int BIT_REV = 1
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic [N*MSB-1:0]   i_frame_in,
   input  wire logic               i_frame_valid,
   fft_out_serializer_if.master    m_out,
   output logic                    o_busy,
   output logic                    o_shadow_full,
   output logic                    o_overrun
);
   localparam int              c_IW   = $clog2(N);
   localparam logic [c_IW-1:0] c_LAST = c_IW'(N - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [N*MSB-1:0]    r_a;
   logic [N*MSB-1:0]    w_a_nxt;
   logic [N*MSB-1:0]    r_s;
   logic [N*MSB-1:0]    w_s_nxt;
   logic [c_IW-1:0]     r_cnt;
   logic [c_IW-1:0]     w_cnt_nxt;
   logic                r_shadow_full;
   logic                w_sf_nxt;
   logic                r_overrun;
   logic                w_ovr_nxt;
   logic [c_IW-1:0]     w_rd_idx;
   logic                w_valid;
   logic                w_hs;
   logic                w_eof;

   assign w_valid = (r_state == ST_SEND);
   assign w_hs    = w_valid && m_out.out_ready;
   assign w_eof   = w_hs && (r_cnt == c_LAST);

   generate
      if (BIT_REV != 0) begin : g_rev
         for (genvar b = 0; b < c_IW; b++) begin : g_bit
            assign w_rd_idx[b] = r_cnt[c_IW-1-b];
         end
      end else begin : g_nat
         assign w_rd_idx = r_cnt;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_a           <= '0;
         r_s           <= '0;
         r_cnt         <= '0;
         r_shadow_full <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_a           <= w_a_nxt;
         r_s           <= w_s_nxt;
         r_cnt         <= w_cnt_nxt;
         r_shadow_full <= w_sf_nxt;
         r_overrun     <= w_ovr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_s_nxt     = r_s;
      w_cnt_nxt   = r_cnt;
      w_sf_nxt    = r_shadow_full;
      w_ovr_nxt   = r_overrun;
      case (r_state)
         ST_IDLE: begin
            if (i_frame_valid) begin
               w_a_nxt     = i_frame_in;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (w_eof) begin
               // Shadow frame outranks a same-cycle arrival, which then refills the shadow.
               w_cnt_nxt = '0;
               if (r_shadow_full) begin
                  w_a_nxt = r_s;
                  if (i_frame_valid) begin
                     w_s_nxt = i_frame_in;
                  end else begin
                     w_sf_nxt = 1'b0;
                  end
               end else if (i_frame_valid) begin
                  w_a_nxt = i_frame_in;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               if (w_hs) begin
                  w_cnt_nxt = r_cnt + c_IW'(1);
               end
               if (i_frame_valid) begin
                  if (!r_shadow_full) begin
                     w_s_nxt  = i_frame_in;
                     w_sf_nxt = 1'b1;
                  end else begin
                     w_ovr_nxt = 1'b1;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign m_out.out_valid = w_valid;
   assign m_out.out_index = r_cnt;
   assign m_out.out_last  = w_valid && (r_cnt == c_LAST);
   assign m_out.data_out  = r_a[int'(w_rd_idx)*MSB +: MSB];
   assign o_busy          = w_valid;
   assign o_shadow_full   = r_shadow_full;
   assign o_overrun       = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_fft_out_serializer.sv
// ============================================================================
// Module  : tb_fft_out_serializer
// Brief   : Frame-level queue model checking natural and bit-reversed units.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_out_serializer;
   localparam int N   = 16;
   localparam int MSB = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [N*MSB-1:0]   frame_in = '0;
   logic               fv = 1'b0;
   logic               ready = 1'b1;
   logic               busy0, sf0, ovr0, busy1, sf1, ovr1;

   fft_out_serializer_if #(.N(N), .MSB(MSB)) if0 ();
   fft_out_serializer_if #(.N(N), .MSB(MSB)) if1 ();
   assign if0.out_ready = ready;
   assign if1.out_ready = ready;

   fft_out_serializer #(.N(N), .MSB(MSB), .BIT_REV(0)) u_dut0 (
      .clk(clk), .rst(rst), .i_frame_in(frame_in), .i_frame_valid(fv),
      .m_out(if0.master), .o_busy(busy0), .o_shadow_full(sf0), .o_overrun(ovr0));
   fft_out_serializer #(.N(N), .MSB(MSB), .BIT_REV(1)) u_dut1 (
      .clk(clk), .rst(rst), .i_frame_in(frame_in), .i_frame_valid(fv),
      .m_out(if1.master), .o_busy(busy1), .o_shadow_full(sf1), .o_overrun(ovr1));

   always #5 clk = ~clk;

   typedef struct { int base; int idx; } ent_t;
   ent_t       q[$];
   logic [15:0] obs0[$];
   logic [15:0] obs1[$];
   int         hs_cnt = 0;
   int         fbase  = 0;
   logic       m_ovr  = 1'b0;
   int         errors = 0;
   int         checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int rev4(input int v);
      int r = 0;
      for (int b = 0; b < 4; b++) r = r | (((v >> b) & 1) << (3 - b));
      return r;
   endfunction

   // Frames in flight = samples still owed rounded up to whole frames; two is capacity.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_ovr <= 1'b0;
      end else begin
         if (q.size() > 0 && ready) begin
            obs0.push_back(if0.data_out);
            obs1.push_back(if1.data_out);
            hs_cnt++;
            void'(q.pop_front());
         end
         if (fv) begin
            if ((q.size() + N - 1) / N < 2) begin
               for (int k = 0; k < N; k++) q.push_back('{fbase, k});
            end else begin
               m_ovr <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic ev;
      ev = (q.size() > 0);
      chk("valid0", 32'(if0.out_valid), 32'(ev));
      chk("valid1", 32'(if1.out_valid), 32'(ev));
      chk("busy0", 32'(busy0), 32'(ev));
      chk("busy1", 32'(busy1), 32'(ev));
      chk("shadow0", 32'(sf0), 32'(q.size() > N));
      chk("shadow1", 32'(sf1), 32'(q.size() > N));
      chk("overrun0", 32'(ovr0), 32'(m_ovr));
      chk("overrun1", 32'(ovr1), 32'(m_ovr));
      if (ev) begin
         chk("data_nat", 32'(if0.data_out), 32'(16'(q[0].base + q[0].idx)));
         chk("data_rev", 32'(if1.data_out), 32'(16'(q[0].base + rev4(q[0].idx))));
         chk("index0", 32'(if0.out_index), 32'(q[0].idx));
         chk("index1", 32'(if1.out_index), 32'(q[0].idx));
         chk("last0", 32'(if0.out_last), 32'(q[0].idx == N - 1));
         chk("last1", 32'(if1.out_last), 32'(q[0].idx == N - 1));
      end
   end

   task automatic send(input int b);
      fbase = b;
      for (int k = 0; k < N; k++) frame_in[k*MSB +: MSB] = 16'(b + k);
      fv = 1'b1;
      @(posedge clk); #1;
      fv = 1'b0;
   endtask

   task automatic drain(input bit rnd);
      int n = 0;
      while (q.size() > 0 && n < 300) begin
         ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         n++;
      end
      ready = 1'b1;
      chk("drain_done", 32'(q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      obs0.delete();
      obs1.delete();
      hs_cnt = 0;
   endtask

   task automatic all_zero(input string nm);
      chk({nm, "_valid"}, 32'(if0.out_valid | if1.out_valid), 32'd0);
      chk({nm, "_data"}, 32'(if0.data_out | if1.data_out), 32'd0);
      chk({nm, "_index"}, 32'(if0.out_index | if1.out_index), 32'd0);
      chk({nm, "_last"}, 32'(if0.out_last | if1.out_last), 32'd0);
      chk({nm, "_busy"}, 32'(busy0 | busy1), 32'd0);
      chk({nm, "_shadow"}, 32'(sf0 | sf1), 32'd0);
      chk({nm, "_ovr"}, 32'(ovr0 | ovr1), 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Single frame, both orders.
      clear_obs();
      send(16'h1000);
      drain(1'b0);
      chk("single_count", 32'(obs0.size()), 32'd16);
      if (obs0.size() == 16) begin
         for (int i = 0; i < 16; i++) chk("single_seq", 32'(obs0[i]), 32'h1000 + 32'(i));
         chk("rev_s0", 32'(obs1[0]), 32'h1000);
         chk("rev_s1", 32'(obs1[1]), 32'h1008);
         chk("rev_s2", 32'(obs1[2]), 32'h1004);
         chk("rev_s3", 32'(obs1[3]), 32'h100C);
         chk("rev_s4", 32'(obs1[4]), 32'h1002);
         chk("rev_s15", 32'(obs1[15]), 32'h100F);
      end

      // Random backpressure.
      clear_obs();
      send(16'h1000);
      drain(1'b1);
      chk("bp_handshakes", 32'(hs_cnt), 32'd16);

      // Shadow capture and overrun.
      clear_obs();
      send(16'h1000);
      repeat (4) @(posedge clk);
      #1;
      send(16'h2000);
      @(negedge clk);
      chk("shadow_set", 32'(sf0), 32'd1);
      chk("no_ovr_yet", 32'(ovr0), 32'd0);
      @(posedge clk); #1;
      send(16'h3000);
      @(negedge clk);
      chk("ovr_set", 32'(ovr0), 32'd1);
      drain(1'b0);
      chk("shadow_count", 32'(obs0.size()), 32'd32);
      if (obs0.size() == 32) begin
         chk("b_first", 32'(obs0[16]), 32'h2000);
         chk("b_last", 32'(obs0[31]), 32'h200F);
      end

      // Arrival on the end-of-frame handshake with the shadow empty.
      clear_obs();
      send(16'h1000);
      repeat (15) @(posedge clk);
      #1;
      send(16'h6000);
      @(negedge clk);
      chk("simul_valid", 32'(if0.out_valid), 32'd1);
      chk("simul_index", 32'(if0.out_index), 32'd0);
      chk("simul_data", 32'(if0.data_out), 32'h6000);
      chk("simul_shadow", 32'(sf0), 32'd0);
      drain(1'b0);
      chk("simul_count", 32'(obs0.size()), 32'd32);

      // Asynchronous reset mid-frame, with overrun still set from earlier.
      clear_obs();
      send(16'h4000);
      repeat (7) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_index", 32'(if0.out_index), 32'd7);
      chk("pre_rst_ovr", 32'(ovr0), 32'd1);
      #2 rst = 1'b1;
      #1 all_zero("async_rst");
      @(posedge clk); #1;
      all_zero("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("no_resume", 32'(if0.out_valid), 32'd0);
      clear_obs();
      send(16'h5000);
      drain(1'b0);
      chk("post_rst_count", 32'(obs0.size()), 32'd16);
      if (obs0.size() == 16) chk("post_rst_first", 32'(obs0[0]), 32'h5000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end
endmodule

`default_nettype wire
